// File: rtl/bcd2bin_seq.sv
// rtl/bcd2bin_seq.sv - iterative BCD-to-binary converter (reverse double dabble)
module bcd2bin_seq #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [BIN_W-1:0]      bin_out
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int SCR_W = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

    state_t             state_q, state_d;
    logic [SCR_W-1:0]   scratch_q, scratch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic               bad_digit;
    logic [SCR_W-1:0]   shifted;
    logic [SCR_W-1:0]   corrected;

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
        end
    end

    // One step: shift the whole scratch right, then pull every BCD digit >= 8 back by 3.
    always_comb begin
        shifted   = scratch_q >> 1;
        corrected = shifted;
        for (int i = 0; i < DIGITS; i++) begin
            if (shifted[BIN_W + 4*i +: 4] >= 4'd8)
                corrected[BIN_W + 4*i +: 4] = shifted[BIN_W + 4*i +: 4] - 4'd3;
        end
    end

    always_comb begin
        state_d   = state_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        bin_d     = bin_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (bad_digit) begin
                        err_d   = 1'b1;
                        bin_d   = '0;
                        state_d = DONE;
                    end else begin
                        scratch_d = {bcd_in, {BIN_W{1'b0}}};
                        cnt_d     = '0;
                        err_d     = 1'b0;
                        state_d   = CONVERT;
                    end
                end
            end
            CONVERT: begin
                scratch_d = corrected;
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    bin_d   = corrected[BIN_W-1:0];
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            scratch_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            bin_q     <= '0;
        end else begin
            state_q   <= state_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            bin_q     <= bin_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign bin_out = bin_q;
endmodule
